// File: rtl/smoldvi_timing_gen.sv
// Raster timing generator: early (x, y, req, sol, sof) coordinates for the pixel
// source, plus den/hsync/vsync delayed DELAY cycles to align with fetched pixels.
module smoldvi_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int DELAY      = 2,
    parameter int COORD_BITS = 12
) (
    input  logic                  clk_pix,
    input  logic                  rst_pix,
    output logic [COORD_BITS-1:0] x,
    output logic [COORD_BITS-1:0] y,
    output logic                  req,
    output logic                  sol,
    output logic                  sof,
    output logic                  den,
    output logic                  hsync,
    output logic                  vsync
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [COORD_BITS-1:0] H_LAST = COORD_BITS'(H_TOTAL - 1);
    localparam logic [COORD_BITS-1:0] V_LAST = COORD_BITS'(V_TOTAL - 1);
    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

    // Bad parameter sets are rejected at elaboration, never handled at runtime.
    if (H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1 ||
        H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0) begin : g_bad_region
        $error("smoldvi_timing_gen: active/sync regions must be non-empty");
    end
    if (DELAY < 1 || DELAY > 15) begin : g_bad_delay
        $error("smoldvi_timing_gen: DELAY must be 1..15");
    end
    if (H_TOTAL > (1 << COORD_BITS) || V_TOTAL > (1 << COORD_BITS)) begin : g_bad_width
        $error("smoldvi_timing_gen: COORD_BITS too small for raster");
    end

    logic [COORD_BITS-1:0] h_q, h_d;
    logic [COORD_BITS-1:0] v_q, v_d;
    logic                  req_q, req_d;
    logic                  sol_q, sol_d;
    logic                  sof_q, sof_d;
    logic                  hs_e_q, hs_e_d;
    logic                  vs_e_q, vs_e_d;
    logic                  h_wrap;

    always_comb begin
        h_wrap = (h_q == H_LAST);
        h_d    = h_wrap ? '0 : h_q + 1'b1;
        v_d    = v_q;
        if (h_wrap) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
        // Decode the coming position so the flags land in the same cycle as x/y.
        req_d  = (int'(h_d) < H_ACTIVE) && (int'(v_d) < V_ACTIVE);
        sol_d  = (h_d == '0) && (int'(v_d) < V_ACTIVE);
        sof_d  = (h_d == '0) && (v_d == '0);
        hs_e_d = (int'(h_d) >= HS_START) && (int'(h_d) < HS_END);
        vs_e_d = (int'(v_d) >= VS_START) && (int'(v_d) < VS_END);
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            h_q    <= H_LAST;
            v_q    <= V_LAST;
            req_q  <= 1'b0;
            sol_q  <= 1'b0;
            sof_q  <= 1'b0;
            hs_e_q <= 1'b0;
            vs_e_q <= 1'b0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            req_q  <= req_d;
            sol_q  <= sol_d;
            sof_q  <= sof_d;
            hs_e_q <= hs_e_d;
            vs_e_q <= vs_e_d;
        end
    end

    // Sync stages carry the polarity-applied level so the outputs are plain flops.
    logic [DELAY-1:0] den_pipe_q;
    logic [DELAY-1:0] hs_pipe_q;
    logic [DELAY-1:0] vs_pipe_q;

    genvar gi;
    generate
        for (gi = 0; gi < DELAY; gi++) begin : g_stage
            logic den_in, hs_in, vs_in;
            if (gi == 0) begin : g_head
                assign den_in = req_q;
                assign hs_in  = hs_e_q ? HS_ACT : ~HS_ACT;
                assign vs_in  = vs_e_q ? VS_ACT : ~VS_ACT;
            end else begin : g_body
                assign den_in = den_pipe_q[gi-1];
                assign hs_in  = hs_pipe_q[gi-1];
                assign vs_in  = vs_pipe_q[gi-1];
            end
            always_ff @(posedge clk_pix) begin
                if (rst_pix) begin
                    den_pipe_q[gi] <= 1'b0;
                    hs_pipe_q[gi]  <= ~HS_ACT;
                    vs_pipe_q[gi]  <= ~VS_ACT;
                end else begin
                    den_pipe_q[gi] <= den_in;
                    hs_pipe_q[gi]  <= hs_in;
                    vs_pipe_q[gi]  <= vs_in;
                end
            end
        end
    endgenerate

    assign x     = h_q;
    assign y     = v_q;
    assign req   = req_q;
    assign sol   = sol_q;
    assign sof   = sof_q;
    assign den   = den_pipe_q[DELAY-1];
    assign hsync = hs_pipe_q[DELAY-1];
    assign vsync = vs_pipe_q[DELAY-1];

endmodule

// File: tb/tb_smoldvi_timing_gen.sv
// Bench: default-timing instance for startup/line/sync-pulse behaviour, plus a tiny
// raster instance checked every cycle against an arithmetic model under random resets.
module tb_smoldvi_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A: default 640x480 timing ----------------
    logic        rst_a = 1'b1;
    logic [11:0] a_x, a_y;
    logic        a_req, a_sol, a_sof, a_den, a_hs, a_vs;

    smoldvi_timing_gen dut_a (
        .clk_pix(clk), .rst_pix(rst_a), .x(a_x), .y(a_y),
        .req(a_req), .sol(a_sol), .sof(a_sof), .den(a_den),
        .hsync(a_hs), .vsync(a_vs)
    );

    // ---------------- instance B: 8x5 raster, DELAY 3, active-high ----------------
    localparam int BHT = 8, BVT = 5, BFR = BHT * BVT, BDLY = 3;
    logic       rst_b = 1'b1;
    logic [3:0] b_x, b_y;
    logic       b_req, b_sol, b_sof, b_den, b_hs, b_vs;

    smoldvi_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .DELAY(BDLY), .COORD_BITS(4)
    ) dut_b (
        .clk_pix(clk), .rst_pix(rst_b), .x(b_x), .y(b_y),
        .req(b_req), .sol(b_sol), .sof(b_sof), .den(b_den),
        .hsync(b_hs), .vsync(b_vs)
    );

    // Model: n = cycles since reset release (first released edge is n=0); n=-1 is the reset state.
    int n_b = -1;

    function automatic int hpos(input int n);
        return (((n % BFR) + BFR) % BFR) % BHT;
    endfunction
    function automatic int vpos(input int n);
        return (((n % BFR) + BFR) % BFR) / BHT;
    endfunction
    function automatic int req_at(input int n);
        return (n >= 0 && hpos(n) < 4 && vpos(n) < 2) ? 1 : 0;
    endfunction
    function automatic int hs_at(input int n);
        return (n >= 0 && hpos(n) == 5) ? 1 : 0;
    endfunction
    function automatic int vs_at(input int n);
        return (n >= 0 && vpos(n) == 3) ? 1 : 0;
    endfunction

    task automatic tick_b();
        logic r;
        r = rst_b;
        tick();
        n_b = r ? -1 : n_b + 1;
        check("b_x",   int'(b_x), hpos(n_b));
        check("b_y",   int'(b_y), vpos(n_b));
        check("b_req", int'(b_req), req_at(n_b));
        check("b_sol", int'(b_sol), (n_b >= 0 && hpos(n_b) == 0 && vpos(n_b) < 2) ? 1 : 0);
        check("b_sof", int'(b_sof), (n_b >= 0 && hpos(n_b) == 0 && vpos(n_b) == 0) ? 1 : 0);
        check("b_den", int'(b_den), (n_b >= BDLY) ? req_at(n_b - BDLY) : 0);
        check("b_hs",  int'(b_hs),  (n_b >= BDLY) ? hs_at(n_b - BDLY) : 0);
        check("b_vs",  int'(b_vs),  (n_b >= BDLY) ? vs_at(n_b - BDLY) : 0);
    endtask

    task automatic wait_a(input int tx, input int ty, input int budget, input string tag);
        int hit;
        hit = 0;
        for (int i = 0; i < budget; i++) begin
            if (int'(a_x) == tx && (ty < 0 || int'(a_y) == ty)) begin
                hit = 1;
                break;
            end
            tick();
        end
        check(tag, hit, 1);
    endtask

    initial begin
        int first_low, last_low, low_cnt;
        int c_req, c_den, c_sol, c_sof, c_hs, c_vs;

        // ---- A: reset state and startup ----
        rst_a = 1'b1;
        repeat (3) tick();
        check("a_rst_x", int'(a_x), 799);
        check("a_rst_y", int'(a_y), 524);
        check("a_rst_req", int'(a_req), 0);
        check("a_rst_den", int'(a_den), 0);
        check("a_rst_hs", int'(a_hs), 1);
        check("a_rst_vs", int'(a_vs), 1);
        rst_a = 1'b0;
        tick();
        check("a_start_x", int'(a_x), 0);
        check("a_start_y", int'(a_y), 0);
        check("a_start_req", int'(a_req), 1);
        check("a_start_sol", int'(a_sol), 1);
        check("a_start_sof", int'(a_sof), 1);
        check("a_start_den0", int'(a_den), 0);
        tick();
        check("a_start_den1", int'(a_den), 0);
        tick();
        check("a_start_den2", int'(a_den), 1);
        check("a_start_hs", int'(a_hs), 1);
        check("a_start_vs", int'(a_vs), 1);

        // ---- A: line wrap and hsync pulse ----
        wait_a(799, 10, 20000, "a_reach_799_10");
        tick();
        check("a_wrap_x", int'(a_x), 0);
        check("a_wrap_y", int'(a_y), 11);
        check("a_wrap_sol", int'(a_sol), 1);
        check("a_wrap_sof", int'(a_sof), 0);
        wait_a(656, 11, 1000, "a_reach_656");
        first_low = -1; last_low = -1; low_cnt = 0;
        for (int k = 1; k < 200; k++) begin
            tick();
            if (a_hs == 1'b0) begin
                if (first_low < 0) first_low = k;
                last_low = k;
                low_cnt++;
            end
        end
        check("a_hs_start", first_low, 2);
        check("a_hs_len", low_cnt, 96);
        check("a_hs_contig", last_low - first_low + 1, 96);

        // ---- A: reset mid-line while an hsync pulse is in flight ----
        wait_a(657, 12, 1000, "a_reach_657");
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("a_mid_x", int'(a_x), 799);
        check("a_mid_req", int'(a_req), 0);
        check("a_mid_den", int'(a_den), 0);
        check("a_mid_hs", int'(a_hs), 1);
        tick();
        check("a_re_sof", int'(a_sof), 1);
        check("a_re_hs0", int'(a_hs), 1);
        tick();
        check("a_re_hs1", int'(a_hs), 1);
        check("a_re_den1", int'(a_den), 0);
        tick();
        check("a_re_den2", int'(a_den), 1);
        check("a_re_hs2", int'(a_hs), 1);

        // ---- B: one frame of totals after a clean reset ----
        rst_b = 1'b1;
        tick_b();
        tick_b();
        rst_b = 1'b0;
        c_req = 0; c_den = 0; c_sol = 0; c_sof = 0; c_hs = 0; c_vs = 0;
        for (int k = 0; k < BFR + BDLY; k++) begin
            tick_b();
            if (n_b < BFR) begin
                c_req += int'(b_req);
                c_sol += int'(b_sol);
                c_sof += int'(b_sof);
            end
            if (n_b >= BDLY) begin
                c_den += int'(b_den);
                c_hs  += int'(b_hs);
                c_vs  += int'(b_vs);
            end
        end
        check("b_frame_req", c_req, 8);
        check("b_frame_den", c_den, 8);
        check("b_frame_sol", c_sol, 2);
        check("b_frame_sof", c_sof, 1);
        check("b_frame_hs", c_hs, 5);
        check("b_frame_vs", c_vs, 8);

        // ---- B: random reset pulses, every cycle checked against the model ----
        for (int k = 0; k < 1500; k++) begin
            rst_b = ($urandom_range(0, 59) == 0);
            tick_b();
        end
        rst_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
